grid_robot_planner: RTL and testbench

Controller-side counterpart of the grid planning environment model. It drives the robot's move request and the one-hot direction commands: `move_robot` and `ctrl_up`/`ctrl_down`/`ctrl_left`/`ctrl_right`. It keeps a shadow copy of the robot position and follows a fixed wall-aware route from (0,0) to (3K-1,0). It refuses any step that would land in an obstacle's collision zone, and waits instead. It sits between the scheduler, which grants robot moves, and the environment, which reports obstacle positions and `env_error`.

---
 rtl/grid_robot_planner_pkg.sv | 53 +++++
 rtl/grid_robot_planner_if.sv | 19 +
 rtl/grid_robot_planner_collision_chk.sv | 37 +++
 rtl/grid_robot_planner.sv | 167 ++++++++++++++++
 tb/tb_grid_robot_planner.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/grid_robot_planner_pkg.sv
// Shared types and route helpers for the grid robot planner.
// Grid is 3K x 3K with two internal walls: between columns K-1|K (door in rows y >= 2K)
// and between columns 2K-1|2K (door in rows y < 2K).
package planner_pkg;

    localparam int K_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_REQ,
        ST_BLOCKED,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // True when column x has a wall on its east side.
    function automatic logic wall_east_of(input int unsigned x, input int unsigned k);
        return (x == k - 1) || (x == 2 * k - 1);
    endfunction

    // Door through the left wall (K-1|K) is in the upper band of rows.
    function automatic logic left_door_open(input int unsigned y, input int unsigned k);
        return y >= 2 * k;
    endfunction

    // Door through the right wall (2K-1|2K) is in the lower two bands of rows.
    function automatic logic right_door_open(input int unsigned y, input int unsigned k);
        return y < 2 * k;
    endfunction

    // Fixed route from (0,0) to (3K-1,0): climb to the left door, cross,
    // drop to the right door, cross, then descend to row 0 and step right.
    function automatic dir_t route_dir(input int unsigned x, input int unsigned y,
                                       input int unsigned k);
        dir_t d;
        if (x < k)
            d = left_door_open(y, k) ? DIR_RIGHT : DIR_UP;
        else if (x < 2 * k)
            d = right_door_open(y, k) ? DIR_RIGHT : DIR_DOWN;
        else
            d = (y > 0) ? DIR_DOWN : DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/grid_robot_planner_if.sv
// Move handshake between planner (master) and scheduler/environment side (slave).
interface grid_robot_planner_if;
    logic rt_grant;
    logic move_robot;
    logic ctrl_up;
    logic ctrl_down;
    logic ctrl_left;
    logic ctrl_right;

    modport master (
        input  rt_grant,
        output move_robot, ctrl_up, ctrl_down, ctrl_left, ctrl_right
    );

    modport slave (
        output rt_grant,
        input  move_robot, ctrl_up, ctrl_down, ctrl_left, ctrl_right
    );
endinterface

// File: rtl/grid_robot_planner_collision_chk.sv
// Combinational collision-zone check: a cell is unsafe when it shares a row with an
// obstacle and lies within one column of it. Compared at CW+1 bits so x+1 cannot wrap.
module planner_collision_chk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] nx,
    input  logic [CW-1:0] ny,
    input  logic [CW-1:0] obs1_x,
    input  logic [CW-1:0] obs1_y,
    input  logic [CW-1:0] obs2_x,
    input  logic [CW-1:0] obs2_y,
    output logic          safe
);
    localparam logic [CW:0] ONE_W = (CW+1)'(1);

    logic [CW-1:0] obs_x [2];
    logic [CW-1:0] obs_y [2];
    logic [1:0]    hit;

    assign obs_x[0] = obs1_x;
    assign obs_y[0] = obs1_y;
    assign obs_x[1] = obs2_x;
    assign obs_y[1] = obs2_y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_obs
            logic [CW:0] nx_w;
            logic [CW:0] ox_w;
            assign nx_w    = {1'b0, nx};
            assign ox_w    = {1'b0, obs_x[gi]};
            assign hit[gi] = (ny == obs_y[gi]) && (nx_w + ONE_W >= ox_w) && (nx_w <= ox_w + ONE_W);
        end
    endgenerate

    assign safe = ~|hit;
endmodule

// File: rtl/grid_robot_planner.sv
// Grid robot planner: walks a fixed wall-aware route from (0,0) to (3K-1,0), requesting
// one move at a time and waiting whenever the next cell is inside an obstacle's zone.
// Optional feature macro: PLANNER_WAIT_TIMEOUT_EN (blocked-wait timeout to FAIL).
module grid_robot_planner
    import planner_pkg::*;
#(
    parameter int K        = K_DEFAULT,
    parameter int CW       = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 env_error,
    grid_robot_planner_if.master rt,
    input  logic [CW-1:0]        obs1_x,
    input  logic [CW-1:0]        obs1_y,
    input  logic [CW-1:0]        obs2_x,
    input  logic [CW-1:0]        obs2_y,
    output logic [CW-1:0]        robot_x,
    output logic [CW-1:0]        robot_y,
    output logic                 at_goal,
    output logic                 blocked,
    output logic                 fail,
    output logic [7:0]           steps
);
    localparam logic [CW-1:0] GOAL_X = CW'(3 * K - 1);

    if (3 * K - 1 >= (1 << CW)) begin : g_bad_cw
        $error("CW too narrow for a 3K x 3K grid");
    end
    if (WAIT_MAX < 1 || WAIT_MAX > 256) begin : g_bad_wait_max
        $error("WAIT_MAX must be in 1..256");
    end

    state_t        state_reg, state_next;
    logic [CW-1:0] robot_x_reg, robot_y_reg;
    logic [7:0]    steps_reg;
    logic          at_goal_reg, blocked_reg, fail_reg;

    dir_t          dir;
    logic [CW-1:0] nx, ny;
    logic          safe;
    logic          at_goal_pos;
    logic          move_ok;
    logic          timeout;

    // Direction and candidate cell follow the shadow position, so they stay stable in REQ/BLOCKED.
    always_comb begin
        dir = route_dir(32'(robot_x_reg), 32'(robot_y_reg), K);
        nx  = robot_x_reg;
        ny  = robot_y_reg;
        unique case (dir)
            DIR_UP:    ny = robot_y_reg + CW'(1);
            DIR_DOWN:  ny = robot_y_reg - CW'(1);
            DIR_LEFT:  nx = robot_x_reg - CW'(1);
            DIR_RIGHT: nx = robot_x_reg + CW'(1);
            default: ;
        endcase
    end

    planner_collision_chk #(.CW(CW)) u_collision_chk (
        .nx     (nx),
        .ny     (ny),
        .obs1_x (obs1_x),
        .obs1_y (obs1_y),
        .obs2_x (obs2_x),
        .obs2_y (obs2_y),
        .safe   (safe)
    );

    assign at_goal_pos = (robot_x_reg == GOAL_X) && (robot_y_reg == '0);

`ifdef PLANNER_WAIT_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    // Counts cycles spent in BLOCKED; held at zero elsewhere so each entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_reg <= '0;
        else if (state_reg != ST_BLOCKED)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end

    assign timeout = (state_reg == ST_BLOCKED) && (wait_cnt_reg == 8'(WAIT_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic; env_error overrides every transition out of a non-IDLE state.
    always_comb begin
        state_next = state_reg;
        move_ok    = 1'b0;
        unique case (state_reg)
            ST_IDLE: if (start) state_next = ST_PLAN;
            ST_PLAN: begin
                if (env_error)        state_next = ST_FAIL;
                else if (at_goal_pos) state_next = ST_DONE;
                else if (safe)        state_next = ST_REQ;
                else                  state_next = ST_BLOCKED;
            end
            ST_REQ: begin
                if (env_error) state_next = ST_FAIL;
                else if (safe && rt.rt_grant) begin
                    move_ok    = 1'b1;
                    state_next = ST_PLAN;
                end
                else if (!safe) state_next = ST_BLOCKED;
            end
            ST_BLOCKED: begin
                if (env_error)    state_next = ST_FAIL;
                else if (timeout) state_next = ST_FAIL;
                else if (safe)    state_next = ST_REQ;
            end
            ST_DONE, ST_FAIL: ;
            default: state_next = ST_IDLE;
        endcase
    end

    // Move request and one-hot direction, live only while requesting.
    always_comb begin
        rt.move_robot = 1'b0;
        rt.ctrl_up    = 1'b0;
        rt.ctrl_down  = 1'b0;
        rt.ctrl_left  = 1'b0;
        rt.ctrl_right = 1'b0;
        if (state_reg == ST_REQ) begin
            rt.move_robot = safe;
            rt.ctrl_up    = (dir == DIR_UP);
            rt.ctrl_down  = (dir == DIR_DOWN);
            rt.ctrl_left  = (dir == DIR_LEFT);
            rt.ctrl_right = (dir == DIR_RIGHT);
        end
    end

    // State, shadow position, step counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            robot_x_reg <= '0;
            robot_y_reg <= '0;
            steps_reg   <= '0;
            at_goal_reg <= 1'b0;
            blocked_reg <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            at_goal_reg <= (state_next == ST_DONE);
            blocked_reg <= (state_next == ST_BLOCKED);
            fail_reg    <= (state_next == ST_FAIL);
            if (move_ok) begin
                robot_x_reg <= nx;
                robot_y_reg <= ny;
                if (steps_reg != 8'hFF) steps_reg <= steps_reg + 8'd1;
            end
        end
    end

    assign robot_x = robot_x_reg;
    assign robot_y = robot_y_reg;
    assign steps   = steps_reg;
    assign at_goal = at_goal_reg;
    assign blocked = blocked_reg;
    assign fail    = fail_reg;
endmodule

// File: tb/tb_grid_robot_planner.sv
// Directed bench for grid_robot_planner with K=2, CW=4, WAIT_MAX=15.
module tb_grid_robot_planner;
    localparam int CW = 4;

    // Expected one-hot {up,down,left,right} for each step of the K=2 route.
    localparam logic [3:0] ROUTE [13] = '{
        4'b1000, 4'b1000, 4'b1000, 4'b1000,
        4'b0001, 4'b0001,
        4'b0100,
        4'b0001, 4'b0001,
        4'b0100, 4'b0100, 4'b0100,
        4'b0001
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          env_error;
    logic [CW-1:0] obs1_x, obs1_y, obs2_x, obs2_y;
    logic [CW-1:0] robot_x, robot_y;
    logic          at_goal, blocked, fail;
    logic [7:0]    steps;
    logic [3:0]    ctrl_vec;

    int total = 0;
    int bad   = 0;

    grid_robot_planner_if rt_bus ();

    grid_robot_planner #(.K(2), .CW(CW), .WAIT_MAX(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .env_error (env_error),
        .rt        (rt_bus),
        .obs1_x    (obs1_x),
        .obs1_y    (obs1_y),
        .obs2_x    (obs2_x),
        .obs2_y    (obs2_y),
        .robot_x   (robot_x),
        .robot_y   (robot_y),
        .at_goal   (at_goal),
        .blocked   (blocked),
        .fail      (fail),
        .steps     (steps)
    );

    assign ctrl_vec = {rt_bus.ctrl_up, rt_bus.ctrl_down, rt_bus.ctrl_left, rt_bus.ctrl_right};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        start            = 1'b0;
        env_error        = 1'b0;
        rt_bus.rt_grant  = 1'b0;
        obs1_x = 4'd0; obs1_y = 4'd5;
        obs2_x = 4'd5; obs2_y = 4'd5;
        step_clk();
        step_clk();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    task automatic wait_move(input string tag);
        int n = 0;
        while (!rt_bus.move_robot && n < 20) begin
            step_clk();
            n++;
        end
        check_eq(tag, 32'(rt_bus.move_robot), 32'd1);
    endtask

    task automatic wait_blocked(input string tag);
        int n = 0;
        while (!blocked && n < 40) begin
            step_clk();
            n++;
        end
        check_eq(tag, 32'(blocked), 32'd1);
    endtask

    initial begin
        // Reset values while reset is held.
        rst_n = 1'b0; start = 1'b0; env_error = 1'b0; rt_bus.rt_grant = 1'b0;
        obs1_x = 4'd0; obs1_y = 4'd5; obs2_x = 4'd5; obs2_y = 4'd5;
        step_clk();
        check_eq("rst_move", 32'(rt_bus.move_robot), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl_vec), 32'd0);
        check_eq("rst_pos", 32'({robot_x, robot_y}), 32'd0);
        check_eq("rst_steps", 32'(steps), 32'd0);
        check_eq("rst_flags", 32'({at_goal, blocked, fail}), 32'd0);

        // Full unobstructed route with grant held high.
        begin
            int k = 0;
            int goal_edge = 0;
            do_reset();
            rt_bus.rt_grant = 1'b1;
            pulse_start();
            for (int e = 1; e <= 40; e++) begin
                if (rt_bus.move_robot) begin
                    if (k < 13) check_eq($sformatf("route_%0d", k), 32'(ctrl_vec), 32'(ROUTE[k]));
                    k++;
                end
                step_clk();
                if (at_goal && goal_edge == 0) goal_edge = e;
            end
            check_eq("route_len", 32'(k), 32'd13);
            check_eq("goal_edge", 32'(goal_edge), 32'd27);
            check_eq("goal_steps", 32'(steps), 32'd13);
            check_eq("goal_x", 32'(robot_x), 32'd5);
            check_eq("goal_y", 32'(robot_y), 32'd0);
        end

        // Request held without a grant.
        begin
            int stable = 0;
            do_reset();
            pulse_start();
            wait_move("hold_req");
            for (int i = 0; i < 5; i++) begin
                if (rt_bus.move_robot && ctrl_vec == 4'b1000 && robot_y == 4'd0 && steps == 8'd0)
                    stable++;
                step_clk();
            end
            check_eq("hold_stable", 32'(stable), 32'd5);
            rt_bus.rt_grant = 1'b1;
            step_clk();
            check_eq("hold_y", 32'(robot_y), 32'd1);
            check_eq("hold_steps", 32'(steps), 32'd1);
        end

        // Obstacle in front of the robot at (2,4), then moved clear.
        do_reset();
        obs1_x = 4'd3; obs1_y = 4'd3;
        rt_bus.rt_grant = 1'b1;
        pulse_start();
        wait_blocked("blk_enter");
        check_eq("blk_pos", 32'({robot_x, robot_y}), 32'({4'd2, 4'd4}));
        check_eq("blk_steps", 32'(steps), 32'd6);
        check_eq("blk_move", 32'(rt_bus.move_robot), 32'd0);
        obs1_x = 4'd5;
        step_clk();
        check_eq("unblk_move", 32'(rt_bus.move_robot), 32'd1);
        check_eq("unblk_dir", 32'(ctrl_vec), 32'b0100);
        check_eq("unblk_flag", 32'(blocked), 32'd0);
        obs1_x = 4'd0; obs1_y = 4'd5;
        step_clk();
        check_eq("unblk_pos", 32'({robot_x, robot_y}), 32'({4'd2, 4'd3}));

        // Obstacle held in place: timeout or indefinite wait.
        do_reset();
        obs1_x = 4'd3; obs1_y = 4'd3;
        rt_bus.rt_grant = 1'b1;
        pulse_start();
        wait_blocked("wait_enter");
`ifdef PLANNER_WAIT_TIMEOUT_EN
        repeat (14) step_clk();
        check_eq("to_early", 32'(fail), 32'd0);
        step_clk();
        check_eq("to_fail", 32'(fail), 32'd1);
`else
        repeat (100) step_clk();
        check_eq("wait_blocked", 32'(blocked), 32'd1);
        check_eq("wait_nofail", 32'(fail), 32'd0);
`endif

        // env_error and grant in the same REQ cycle.
        do_reset();
        pulse_start();
        wait_move("err_req");
        env_error       = 1'b1;
        rt_bus.rt_grant = 1'b1;
        step_clk();
        env_error = 1'b0;
        check_eq("err_fail", 32'(fail), 32'd1);
        check_eq("err_pos", 32'({robot_x, robot_y}), 32'd0);
        check_eq("err_steps", 32'(steps), 32'd0);
        check_eq("err_move", 32'(rt_bus.move_robot), 32'd0);
        step_clk();
        check_eq("err_sticky", 32'({fail, rt_bus.move_robot}), 32'b10);

        // Asynchronous reset in the middle of the route.
        begin
            int n = 0;
            do_reset();
            rt_bus.rt_grant = 1'b1;
            pulse_start();
            while (steps != 8'd6 && n < 40) begin
                step_clk();
                n++;
            end
            check_eq("mid_steps", 32'(steps), 32'd6);
            step_clk();
            check_eq("mid_move", 32'(rt_bus.move_robot), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check_eq("arst_move", 32'(rt_bus.move_robot), 32'd0);
            check_eq("arst_ctrl", 32'(ctrl_vec), 32'd0);
            check_eq("arst_pos", 32'({robot_x, robot_y}), 32'd0);
            check_eq("arst_steps", 32'(steps), 32'd0);
            rst_n = 1'b1;
            pulse_start();
            step_clk();
            step_clk();
            check_eq("restart_pos", 32'({robot_x, robot_y}), 32'({4'd0, 4'd1}));
            check_eq("restart_steps", 32'(steps), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
